// File: rtl/rop3_feeder.sv
// rop3 command serializer: drives P, S, D onto Bitmap, then returns the engine Result (optional timeout: ROP3_FEEDER_TIMEOUT_EN).
// Latency: P/S/D on cycles t+1..t+3 after accept; result registered one edge after rop_valid in WAIT.
// Backpressure: one command in flight; in_ready only in IDLE; result held until out_valid && out_ready.
module rop3_feeder #(
  parameter int N       = 8,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_mode,
  input  logic [N-1:0] in_p,
  input  logic [N-1:0] in_s,
  input  logic [N-1:0] in_d,
  output logic [7:0]   Mode,
  output logic [N-1:0] Bitmap,
  input  logic         rop_valid,
  input  logic [N-1:0] rop_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [7:0]   out_mode,
  output logic         out_err
);

  typedef enum logic [2:0] {IDLE, SEND_P, SEND_S, SEND_D, WAIT, DONE} state_t;

  state_t       state;
  logic [N-1:0] s_q;
  logic [N-1:0] d_q;

  if (2**TO_W <= TIMEOUT) begin : g_cfg_check
    $error("rop3_feeder: 2**TO_W must exceed TIMEOUT");
  end

  assign in_ready = (state == IDLE);

`ifdef ROP3_FEEDER_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            err_q;
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  // Mode doubles as the latched command mode for the whole operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      Mode       <= '0;
      Bitmap     <= '0;
      s_q        <= '0;
      d_q        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_mode   <= '0;
`ifdef ROP3_FEEDER_TIMEOUT_EN
      to_cnt     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            Mode   <= in_mode;
            Bitmap <= in_p;
            s_q    <= in_s;
            d_q    <= in_d;
            state  <= SEND_P;
          end
        end
        SEND_P: begin
          Bitmap <= s_q;
          state  <= SEND_S;
        end
        SEND_S: begin
          Bitmap <= d_q;
          state  <= SEND_D;
        end
        SEND_D: begin
          Bitmap <= '0;
`ifdef ROP3_FEEDER_TIMEOUT_EN
          to_cnt <= '0;
`endif
          state  <= WAIT;
        end
        WAIT: begin
          // A real result always beats a timeout landing on the same edge.
          if (rop_valid) begin
            out_result <= rop_result;
            out_mode   <= Mode;
            out_valid  <= 1'b1;
`ifdef ROP3_FEEDER_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            state      <= DONE;
          end
`ifdef ROP3_FEEDER_TIMEOUT_EN
          else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            out_result <= '0;
            out_mode   <= Mode;
            out_valid  <= 1'b1;
            err_q      <= 1'b1;
            state      <= DONE;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            Mode      <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rop3_feeder.sv
// Bench for rop3_feeder: behavioural engine model plus per-scenario tasks with inline checks.
module tb_rop3_feeder;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_mode = '0;
  logic [N-1:0] in_p = '0, in_s = '0, in_d = '0;
  logic [7:0]   Mode;
  logic [N-1:0] Bitmap;
  logic         rop_valid = 1'b0;
  logic [N-1:0] rop_result = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] out_result;
  logic [7:0]   out_mode;
  logic         out_err;

  int total = 0;
  int bad   = 0;

  // engine model controls and state
  int     eng_lat    = 1;
  bit     eng_silent = 0;
  bit     eng_stale  = 0;
  bit     eng_busy   = 0;
  int     eng_cnt    = 0;
  int     acc_cnt    = 0;
  logic [7:0]   em;
  logic [N-1:0] ep, es, ed;

  always #5 clk = ~clk;

  rop3_feeder #(.N(N), .TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_p(in_p), .in_s(in_s), .in_d(in_d),
    .Mode(Mode), .Bitmap(Bitmap),
    .rop_valid(rop_valid), .rop_result(rop_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_mode(out_mode), .out_err(out_err)
  );

  // ROP3 truth-table lookup: bit i of result = mode[{P[i],S[i],D[i]}]
  function automatic logic [N-1:0] rop3(input logic [7:0] m, input logic [N-1:0] p, s, d);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m[{p[i], s[i], d[i]}];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) eng_busy = 0;
    else if (in_valid && in_ready) begin
      eng_busy = 1;
      eng_cnt  = 0;
      acc_cnt++;
    end
  end

  // Engine: samples the bus like the real one does, answers eng_lat edges into WAIT.
  always @(negedge clk) begin
    rop_valid = 1'b0;
    if (eng_busy) begin
      eng_cnt++;
      if (eng_cnt == 1) ep = Bitmap;
      if (eng_cnt == 2) es = Bitmap;
      if (eng_cnt == 3) begin ed = Bitmap; em = Mode; end
      if (eng_stale && eng_cnt == 2) begin rop_valid = 1'b1; rop_result = 8'h5a; end
      if (!eng_silent && eng_cnt == 3 + eng_lat) begin
        rop_valid  = 1'b1;
        rop_result = rop3(em, ep, es, ed);
        eng_busy   = 0;
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    #1;
    total++;
    if ({in_ready, Mode, Bitmap, out_valid, out_result, out_mode, out_err} !== {1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got rdy=%b mode=%h bm=%h ov=%b res=%h om=%h err=%b", in_ready, Mode, Bitmap, out_valid, out_result, out_mode, out_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    for (int k = 0; k < 8; k++) begin
      logic [7:0]   m;
      logic [N-1:0] p, s, d, exp_r;
      int lat, n;
      if (k == 0) begin
        m = 8'hc0; p = 8'hf0; s = 8'hcc; d = 8'haa; lat = 1;
      end else begin
        m = 8'($urandom); p = 8'($urandom); s = 8'($urandom); d = 8'($urandom);
        lat = $urandom_range(1, 4);
      end
      exp_r   = rop3(m, p, s, d);
      eng_lat = lat;
      @(negedge clk);
      in_mode = m; in_p = p; in_s = s; in_d = d; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (Bitmap !== p || Mode !== m) begin bad++; $display("FAIL basic_p k=%0d got bm=%h mode=%h exp bm=%h mode=%h", k, Bitmap, Mode, p, m); end
      @(negedge clk);
      total++;
      if (Bitmap !== s || Mode !== m) begin bad++; $display("FAIL basic_s k=%0d got bm=%h mode=%h exp bm=%h mode=%h", k, Bitmap, Mode, s, m); end
      @(negedge clk);
      total++;
      if (Bitmap !== d || Mode !== m) begin bad++; $display("FAIL basic_d k=%0d got bm=%h mode=%h exp bm=%h mode=%h", k, Bitmap, Mode, d, m); end
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      total++;
      if (n !== lat + 1) begin bad++; $display("FAIL basic_latency k=%0d got=%0d exp=%0d", k, n, lat + 1); end
      total++;
      if (out_result !== exp_r || out_mode !== m || out_err !== 1'b0) begin
        bad++; $display("FAIL basic_result k=%0d got res=%h mode=%h err=%b exp res=%h mode=%h err=0", k, out_result, out_mode, out_err, exp_r, m);
      end
      if (k == 0) begin
        total++;
        if (out_result !== 8'hc0) begin bad++; $display("FAIL basic_p_and_s got=%h exp=c0", out_result); end
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || Mode !== 8'h00) begin
        bad++; $display("FAIL basic_return_idle k=%0d got ov=%b rdy=%b mode=%h exp ov=0 rdy=1 mode=00", k, out_valid, in_ready, Mode);
      end
    end
  endtask

  task automatic test_hold;
    logic [N-1:0] p, s, d, exp_r;
    int n;
    p = 8'($urandom); s = 8'($urandom); d = 8'($urandom);
    exp_r = rop3(8'h3c, p, s, d);
    eng_lat = 1;
    out_ready = 1'b0;
    @(negedge clk);
    in_mode = 8'h3c; in_p = p; in_s = s; in_d = d; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_result !== exp_r || out_mode !== 8'h3c || in_ready !== 1'b0) begin
        bad++; $display("FAIL hold_stable i=%0d got ov=%b res=%h mode=%h rdy=%b exp ov=1 res=%h mode=3c rdy=0", i, out_valid, out_result, out_mode, in_ready, exp_r);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL hold_release got ov=%b rdy=%b exp ov=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_stale;
    int n;
    eng_stale = 1; eng_lat = 2;
    @(negedge clk);
    in_mode = 8'h33; in_p = 8'hf0; in_s = 8'hcc; in_d = 8'haa; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    total++;
    if (out_valid !== 1'b1 || out_result !== 8'h33 || out_mode !== 8'h33) begin
      bad++; $display("FAIL stale_ignored got ov=%b res=%h mode=%h exp ov=1 res=33 mode=33", out_valid, out_result, out_mode);
    end
    eng_stale = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [7:0]   modes [3];
    logic [N-1:0] ps [3], ss [3], ds [3];
    logic [7:0]   gm [3];
    logic [N-1:0] gr [3];
    int tv [3];
    int got, sent, acc0;
    modes[0] = 8'h00; modes[1] = 8'hff; modes[2] = 8'h66;
    for (int i = 0; i < 3; i++) begin ps[i] = 8'($urandom); ss[i] = 8'($urandom); ds[i] = 8'($urandom); end
    eng_lat = 1; out_ready = 1'b1;
    got = 0; sent = 0; acc0 = acc_cnt;
    @(negedge clk);
    in_mode = modes[0]; in_p = ps[0]; in_s = ss[0]; in_d = ds[0]; in_valid = 1'b1;
    for (int c = 0; c < 60 && got < 3; c++) begin
      @(negedge clk);
      if (acc_cnt - acc0 == sent + 1) begin
        sent++;
        if (sent < 3) begin in_mode = modes[sent]; in_p = ps[sent]; in_s = ss[sent]; in_d = ds[sent]; end
        else in_valid = 1'b0;
      end
      if (out_valid === 1'b1) begin gm[got] = out_mode; gr[got] = out_result; tv[got] = c; got++; end
    end
    in_valid = 1'b0;
    total++;
    if (got !== 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", got); end
    for (int i = 0; i < got; i++) begin
      total++;
      if (gm[i] !== modes[i] || gr[i] !== rop3(modes[i], ps[i], ss[i], ds[i])) begin
        bad++; $display("FAIL b2b_result i=%0d got mode=%h res=%h exp mode=%h res=%h", i, gm[i], gr[i], modes[i], rop3(modes[i], ps[i], ss[i], ds[i]));
      end
      if (i > 0) begin
        total++;
        if (tv[i] - tv[i-1] !== 6) begin bad++; $display("FAIL b2b_spacing i=%0d got=%0d exp=6", i, tv[i] - tv[i-1]); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n;
    eng_lat = 1;
    @(negedge clk);
    in_mode = 8'h96; in_p = 8'h12; in_s = 8'h7e; in_d = 8'h81; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (Bitmap !== 8'h00 || Mode !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid got bm=%h mode=%h ov=%b rdy=%b exp bm=00 mode=00 ov=0 rdy=1", Bitmap, Mode, out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    eng_busy = 0;
    @(negedge clk);
    in_mode = 8'h5a; in_p = 8'h0f; in_s = 8'h3c; in_d = 8'h55; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    total++;
    if (n !== 4 || out_result !== rop3(8'h5a, 8'h0f, 8'h3c, 8'h55) || out_mode !== 8'h5a) begin
      bad++; $display("FAIL reset_recover got n=%0d res=%h mode=%h exp n=4 res=%h mode=5a", n, out_result, out_mode, rop3(8'h5a, 8'h0f, 8'h3c, 8'h55));
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int n;
    eng_silent = 1; out_ready = 1'b1;
    @(negedge clk);
    in_mode = 8'h9c; in_p = 8'h11; in_s = 8'h22; in_d = 8'h44; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
`ifdef ROP3_FEEDER_TIMEOUT_EN
    while (out_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    total++;
    if (n !== 20 || out_err !== 1'b1 || out_result !== 8'h00 || out_mode !== 8'h9c) begin
      bad++; $display("FAIL timeout_fire got n=%0d err=%b res=%h mode=%h exp n=20 err=1 res=00 mode=9c", n, out_err, out_result, out_mode);
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL timeout_idle got rdy=%b exp 1", in_ready); end
`else
    while (out_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    total++;
    if (out_valid !== 1'b0 || out_err !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL no_timeout got ov=%b err=%b rdy=%b exp ov=0 err=0 rdy=0", out_valid, out_err, in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    eng_silent = 0;
    eng_busy   = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_stale();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
